fp_wb_arbiter: RTL and testbench

Completion buffer and writeback arbiter placed directly downstream of the pipelined FP execution units (fadd/fsub, fmul, fcvt/misc). Each unit emits a one-cycle completion pulse with a 32-bit result and its exe_p_mux_bus_type control bundle. A completion is never dropped. Simultaneous completions are queued in per-unit FIFOs and drained one per cycle into a single registered writeback port, round-robin. The block also exports a stall to the shared FP pipeline enable and exports every in-flight rd to the hazard unit.

---
 rtl/riscv_types.sv | 22 ++
 rtl/fp_wb_fifo.sv | 109 ++++++++++
 rtl/fp_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fp_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_types.sv
// rtl/riscv_types.sv - shared RISC-V pipeline types and FP writeback unit indices
//
// exe_p_mux_bus_type : control bundle carried alongside an execution result
// FP_NUM_UNITS       : number of FP producer units feeding the writeback arbiter
// FPU_*              : producer index of each FP unit on the arbiter inputs
package riscv_types;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       FP_reg_write;
    logic       mem_to_reg;
    logic [2:0] rm;
  } exe_p_mux_bus_type;

  localparam int FP_NUM_UNITS = 3;

  localparam int FPU_ADDSUB = 0;
  localparam int FPU_MUL    = 1;
  localparam int FPU_MISC   = 2;

endpackage

// File: rtl/fp_wb_fifo.sv
// rtl/fp_wb_fifo.sv - per-unit completion FIFO for the FP writeback arbiter
//
// clk, rst         : clock, asynchronous active-low reset
// flush_i          : empty the FIFO at the next edge (wins over push/pop)
// push_i           : write push_result_i/push_bus_i at the tail
// pop_i            : drop the head entry
// empty_o          : no entries stored
// count_next_o     : occupancy after this cycle's push/pop/flush
// head_result_o    : result of the oldest entry
// head_bus_o       : control bundle of the oldest entry
// slot_rd_o        : rd held in each physical slot (0 when slot empty)
// slot_valid_o     : slot occupied and the entry writes a register
module fp_wb_fifo
  import riscv_types::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [31:0]             push_result_i,
  input  exe_p_mux_bus_type       push_bus_i,
  input  logic                    pop_i,
  output logic                    empty_o,
  output logic [CW-1:0]           count_next_o,
  output logic [31:0]             head_result_o,
  output exe_p_mux_bus_type       head_bus_o,
  output logic [DEPTH-1:0][4:0]   slot_rd_o,
  output logic [DEPTH-1:0]        slot_valid_o
);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]       res_q [DEPTH];
  exe_p_mux_bus_type bus_q [DEPTH];

  logic full;
  logic pop_en;
  logic push_en;
  logic [PW-1:0] slot_off;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_en  = pop_i && !empty_o;
  // A full FIFO can still accept a push when its head leaves in the same cycle.
  assign push_en = push_i && (!full || pop_en);

  assign head_result_o = res_q[rd_ptr_q];
  assign head_bus_o    = bus_q[rd_ptr_q];
  assign count_next_o  = count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_en && !flush_i) begin
      res_q[wr_ptr_q] <= push_result_i;
      bus_q[wr_ptr_q] <= push_bus_i;
    end
  end

  // A physical slot is live when its distance from the read pointer is below count.
  always_comb begin
    slot_rd_o    = '0;
    slot_valid_o = '0;
    slot_off     = '0;
    for (int j = 0; j < DEPTH; j++) begin
      slot_off = PW'(j) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) begin
        slot_rd_o[j]    = bus_q[j].rd;
        slot_valid_o[j] = bus_q[j].reg_write | bus_q[j].FP_reg_write;
      end
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && full && !pop_en && !flush_i));

endmodule

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - FP completion buffer and round-robin writeback arbiter
//
// clk, rst       : clock, asynchronous active-low reset
// clear_i        : flush all buffered and output entries (highest priority)
// unit_valid_i   : one-cycle completion pulse per FP unit
// unit_result_i  : result per FP unit
// unit_bus_i     : control bundle per FP unit
// wb_ready_i     : downstream takes the writeback this cycle
// wb_valid_o     : registered writeback valid
// wb_result_o    : registered writeback data
// wb_bus_o       : registered writeback control bundle
// wb_unit_o      : index of the unit that produced the writeback
// stall_o        : drop the shared FP pipeline enable
// pend_rd_o      : rd of every FIFO slot, slot = unit*DEPTH + index
// pend_valid_o   : slot occupied and entry writes a register
module fp_wb_arbiter
  import riscv_types::*;
#(
  parameter int NUM_UNITS = FP_NUM_UNITS,
  parameter int DEPTH     = 2,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int SW = UW + 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear_i,
  input  logic [NUM_UNITS-1:0]                unit_valid_i,
  input  logic [NUM_UNITS-1:0][31:0]          unit_result_i,
  input  exe_p_mux_bus_type [NUM_UNITS-1:0]   unit_bus_i,
  input  logic                                wb_ready_i,
  output logic                                wb_valid_o,
  output logic [31:0]                         wb_result_o,
  output exe_p_mux_bus_type                   wb_bus_o,
  output logic [UW-1:0]                       wb_unit_o,
  output logic                                stall_o,
  output logic [NUM_UNITS*DEPTH-1:0][4:0]     pend_rd_o,
  output logic [NUM_UNITS*DEPTH-1:0]          pend_valid_o
);

  logic              wb_valid_q,  wb_valid_d;
  logic [31:0]       wb_result_q, wb_result_d;
  exe_p_mux_bus_type wb_bus_q,    wb_bus_d;
  logic [UW-1:0]     wb_unit_q,   wb_unit_d;
  logic [UW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic              stall_q,     stall_d;

  logic [NUM_UNITS-1:0]                fifo_empty;
  logic [NUM_UNITS-1:0][CW-1:0]        fifo_count_next;
  logic [NUM_UNITS-1:0][31:0]          head_result;
  exe_p_mux_bus_type [NUM_UNITS-1:0]   head_bus;

  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] fifo_pop;
  logic [NUM_UNITS-1:0] fifo_push;
  logic [NUM_UNITS-1:0] bypass;
  logic                 out_free;
  logic                 grant_found;
  logic                 grant_valid;
  logic [UW-1:0]        grant_idx;
  logic [SW-1:0]        search_sum;
  logic [UW-1:0]        search_idx;
  logic [31:0]          sel_result;
  exe_p_mux_bus_type    sel_bus;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (clear_i),
      .push_i        (fifo_push[u]),
      .push_result_i (unit_result_i[u]),
      .push_bus_i    (unit_bus_i[u]),
      .pop_i         (fifo_pop[u]),
      .empty_o       (fifo_empty[u]),
      .count_next_o  (fifo_count_next[u]),
      .head_result_o (head_result[u]),
      .head_bus_o    (head_bus[u]),
      .slot_rd_o     (pend_rd_o[u*DEPTH +: DEPTH]),
      .slot_valid_o  (pend_valid_o[u*DEPTH +: DEPTH])
    );
  end

  // A unit competes with its FIFO head; a fresh completion only competes when
  // its FIFO is empty, so it can never pass older entries of the same unit.
  always_comb begin
    out_free    = !wb_valid_q || wb_ready_i;
    cand        = ~fifo_empty | unit_valid_i;
    grant_found = 1'b0;
    grant_idx   = '0;
    search_sum  = '0;
    search_idx  = '0;
    for (int off = 0; off < NUM_UNITS; off++) begin
      search_sum = {1'b0, rr_ptr_q} + SW'(off);
      if (search_sum >= SW'(NUM_UNITS)) search_sum = search_sum - SW'(NUM_UNITS);
      search_idx = search_sum[UW-1:0];
      if (!grant_found && cand[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
    grant_valid = out_free && grant_found && !clear_i;
  end

  always_comb begin
    fifo_pop  = '0;
    fifo_push = '0;
    bypass    = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (grant_valid && (grant_idx == UW'(u))) begin
        fifo_pop[u] = !fifo_empty[u];
        bypass[u]   = fifo_empty[u];
      end
      fifo_push[u] = unit_valid_i[u] && !bypass[u] && !clear_i;
    end
  end

  assign sel_result = fifo_empty[grant_idx] ? unit_result_i[grant_idx] : head_result[grant_idx];
  assign sel_bus    = fifo_empty[grant_idx] ? unit_bus_i[grant_idx]    : head_bus[grant_idx];

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_bus_d    = wb_bus_q;
    wb_unit_d   = wb_unit_q;
    rr_ptr_d    = rr_ptr_q;
    stall_d     = 1'b0;
    if (clear_i) begin
      wb_valid_d  = 1'b0;
      wb_result_d = '0;
      wb_bus_d    = '0;
      wb_unit_d   = '0;
      rr_ptr_d    = '0;
    end else begin
      if (grant_valid) begin
        wb_valid_d  = 1'b1;
        wb_result_d = sel_result;
        wb_bus_d    = sel_bus;
        wb_unit_d   = grant_idx;
        rr_ptr_d    = (grant_idx == UW'(NUM_UNITS - 1)) ? '0 : grant_idx + UW'(1);
      end else if (out_free) begin
        wb_valid_d = 1'b0;
      end
      // Raising stall one entry early leaves room for the completion that is
      // already in the pipeline when the enable drops.
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (fifo_count_next[u] >= CW'(DEPTH - 1)) stall_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_bus_q    <= '0;
      wb_unit_q   <= '0;
      rr_ptr_q    <= '0;
      stall_q     <= 1'b0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_bus_q    <= wb_bus_d;
      wb_unit_q   <= wb_unit_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_q     <= stall_d;
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_result_o = wb_result_q;
  assign wb_bus_o    = wb_bus_q;
  assign wb_unit_o   = wb_unit_q;
  assign stall_o     = stall_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - self-checking bench for fp_wb_arbiter
module tb_fp_wb_arbiter;
  import riscv_types::*;

  localparam int NU = 3;
  localparam int D  = 2;
  localparam int NS = NU * D;
  localparam int BW = $bits(exe_p_mux_bus_type);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic ready = 1'b0;
  logic [NU-1:0] uv = '0;
  logic [NU-1:0][31:0] ures = '0;
  exe_p_mux_bus_type [NU-1:0] ubus = '0;

  logic wb_valid;
  logic [31:0] wb_result;
  exe_p_mux_bus_type wb_bus;
  logic [1:0] wb_unit;
  logic stall;
  logic [NS-1:0][4:0] pend_rd;
  logic [NS-1:0] pend_valid;

  fp_wb_arbiter #(.NUM_UNITS(NU), .DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clr),
    .unit_valid_i  (uv),
    .unit_result_i (ures),
    .unit_bus_i    (ubus),
    .wb_ready_i    (ready),
    .wb_valid_o    (wb_valid),
    .wb_result_o   (wb_result),
    .wb_bus_o      (wb_bus),
    .wb_unit_o     (wb_unit),
    .stall_o       (stall),
    .pend_rd_o     (pend_rd),
    .pend_valid_o  (pend_valid)
  );

  always #5 clk = ~clk;

  // Reference model: one ordered list of buffered completions tagged by unit,
  // plus the output register, round-robin pointer and stall flag.
  typedef struct {
    logic [31:0]       res;
    exe_p_mux_bus_type bus;
    int                unit;
    int                slot;
  } ent_t;

  ent_t mq[$];
  int wcnt[NU];
  bit ov;
  logic [31:0] ores;
  exe_p_mux_bus_type obus;
  int ounit;
  int rr;
  bit mstall;

  int vectors = 0;
  int fails = 0;

  task automatic model_reset();
    mq.delete();
    foreach (wcnt[u]) wcnt[u] = 0;
    ov = 0; ores = '0; obus = '0; ounit = 0; rr = 0; mstall = 0;
  endtask

  function automatic int ucount(int u);
    int n = 0;
    foreach (mq[i]) if (mq[i].unit == u) n++;
    return n;
  endfunction

  task automatic model_edge();
    bit free;
    int g, byp, hi;
    if (clr) begin
      model_reset();
      return;
    end
    free = !ov || ready;
    g = -1; byp = -1; hi = -1;
    if (free) begin
      for (int off = 0; off < NU; off++) begin
        int idx;
        idx = (rr + off) % NU;
        if (g < 0 && (ucount(idx) > 0 || uv[idx])) g = idx;
      end
    end
    if (g >= 0) begin
      foreach (mq[i]) if (hi < 0 && mq[i].unit == g) hi = i;
      if (hi >= 0) begin
        ores = mq[hi].res; obus = mq[hi].bus; mq.delete(hi);
      end else begin
        ores = ures[g]; obus = ubus[g]; byp = g;
      end
      ov = 1; ounit = g; rr = (g + 1) % NU;
    end else if (free) begin
      ov = 0;
    end
    for (int u = 0; u < NU; u++) begin
      if (uv[u] && u != byp) begin
        ent_t e;
        e.res = ures[u]; e.bus = ubus[u]; e.unit = u; e.slot = wcnt[u] % D;
        mq.push_back(e);
        wcnt[u]++;
      end
    end
    mstall = 0;
    for (int u = 0; u < NU; u++) if (ucount(u) >= D - 1) mstall = 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NS-1:0][4:0] eprd;
    logic [NS-1:0] epv;
    eprd = '0; epv = '0;
    foreach (mq[i]) begin
      int k;
      k = mq[i].unit * D + mq[i].slot;
      eprd[k] = mq[i].bus.rd;
      epv[k]  = mq[i].bus.reg_write | mq[i].bus.FP_reg_write;
    end
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'(ov));
    if (ov) begin
      chk({tag, ".wb_result"}, 64'(wb_result), 64'(ores));
      chk({tag, ".wb_bus"}, 64'(wb_bus), 64'(obus));
      chk({tag, ".wb_unit"}, 64'(wb_unit), 64'(ounit));
    end
    chk({tag, ".stall"}, 64'(stall), 64'(mstall));
    chk({tag, ".pend_valid"}, 64'(pend_valid), 64'(epv));
    chk({tag, ".pend_rd"}, 64'(pend_rd), 64'(eprd));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic exe_p_mux_bus_type mk_bus(input logic [4:0] rd, input logic rw, input logic frw);
    exe_p_mux_bus_type b;
    b = '0; b.rd = rd; b.reg_write = rw; b.FP_reg_write = frw;
    return b;
  endfunction

  task automatic drive(input int u, input logic [31:0] r, input exe_p_mux_bus_type b);
    uv[u] = 1'b1; ures[u] = r; ubus[u] = b;
  endtask

  task automatic drive_rand(input int u);
    logic [BW-1:0] rb;
    rb = BW'($urandom());
    drive(u, $urandom(), rb);
  endtask

  initial begin
    int exp4[4];
    exp4[0] = 0; exp4[1] = 2; exp4[2] = 0; exp4[3] = 2;

    // Reset state
    #12;
    model_reset();
    check_all("reset");
    chk("reset.wb_result", 64'(wb_result), 64'd0);
    chk("reset.wb_unit", 64'(wb_unit), 64'd0);
    rst = 1'b1;

    // 1: single completion, one-cycle latency
    ready = 1'b1;
    drive(0, 32'h3F80_0000, mk_bus(5'd5, 1'b0, 1'b1));
    step("t1");
    chk("t1.valid", 64'(wb_valid), 64'd1);
    chk("t1.result", 64'(wb_result), 64'h3F80_0000);
    chk("t1.rd", 64'(wb_bus.rd), 64'd5);
    chk("t1.stall", 64'(stall), 64'd0);
    uv = '0;
    step("t1.drain");

    // 2: triple collision from rr_ptr = 0
    clr = 1'b1; step("t2.clr"); clr = 1'b0;
    drive(0, 32'hAAAA_0000, mk_bus(5'd1, 1'b0, 1'b1));
    drive(1, 32'hBBBB_0000, mk_bus(5'd2, 1'b1, 1'b0));
    drive(2, 32'hCCCC_0000, mk_bus(5'd3, 1'b0, 1'b1));
    step("t2.c0");
    chk("t2.stall", 64'(stall), 64'd1);
    uv = '0;
    for (int i = 0; i < 3; i++) step("t2.drain");

    // 3: backpressure with two unit-1 completions
    ready = 1'b0;
    drive(1, 32'h1111_0001, mk_bus(5'd7, 1'b0, 1'b1));
    step("t3.a");
    drive(1, 32'h1111_0002, mk_bus(5'd8, 1'b0, 1'b1));
    step("t3.b");
    uv = '0;
    step("t3.c");
    step("t3.d");
    chk("t3.hold", 64'(wb_result), 64'h1111_0001);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) step("t3.rel");

    // 4: round-robin fairness between units 0 and 2
    clr = 1'b1; step("t4.clr"); clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand(0);
      drive_rand(2);
      step("t4");
      chk("t4.grant", 64'(wb_unit), 64'(exp4[i]));
    end
    uv = '0;
    for (int i = 0; i < 5; i++) step("t4.drain");

    // 5: flush with entries buffered and output valid
    ready = 1'b0;
    drive_rand(0); drive_rand(1); drive_rand(2);
    step("t5.a");
    uv = '0; drive_rand(0);
    step("t5.b");
    clr = 1'b1; drive_rand(0);
    step("t5.clr");
    chk("t5.valid", 64'(wb_valid), 64'd0);
    chk("t5.pend", 64'(pend_valid), 64'd0);
    chk("t5.stall", 64'(stall), 64'd0);
    clr = 1'b0; uv = '0; ready = 1'b1;
    step("t5.after");
    chk("t5.dropped", 64'(wb_valid), 64'd0);

    // 6: asynchronous reset mid-drain
    ready = 1'b0;
    drive_rand(1); drive_rand(2);
    step("t6.a");
    uv = '0; ready = 1'b1;
    step("t6.b");
    rst = 1'b0;
    #2;
    model_reset();
    check_all("t6.rst");
    chk("t6.rst.result", 64'(wb_result), 64'd0);
    chk("t6.rst.unit", 64'(wb_unit), 64'd0);
    #1;
    rst = 1'b1;
    drive_rand(2);
    step("t6.c");
    chk("t6.valid", 64'(wb_valid), 64'd1);
    chk("t6.unit", 64'(wb_unit), 64'd2);
    uv = '0;
    step("t6.d");

    // Random traffic honouring the stall
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 49) == 0);
      ready = ($urandom_range(0, 3) != 0);
      uv = '0;
      for (int u = 0; u < NU; u++) begin
        if (!mstall && $urandom_range(0, 1) == 1) drive_rand(u);
      end
      step("rnd");
    end
    clr = 1'b0; uv = '0; ready = 1'b1;
    for (int i = 0; i < 6; i++) step("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
